// File: rtl/cpu_sequencer.sv
// Purpose: multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer that owns the PC and issues regfile/dmem strobes.
// Latency: 4 cycles for ALU/jump ops, 4+N for lw/sw (N MEM cycles up to dmem_ready), 2 cycles from FETCH to HALT.
// Backpressure: MEM holds until dmem_ready; HOLD in step_mode waits for a step pulse; HALT is left only by reset.
module cpu_sequencer #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  input  logic              dmem_ready,
  input  logic              step_mode,
  input  logic              step,
  output logic [ADDR_W-1:0] pc_o,
  output logic [31:0]       ir,
  output logic              gr_we,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic              halted,
  output logic              illegal,
  output logic [2:0]        stage,
  output logic [31:0]       instr_count
);

  // State encoding is visible on the stage port, so the values are fixed.
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HOLD   = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_ADDI = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_JALR = 4'h2;
  localparam logic [3:0] OP_JEQ  = 4'h3;
  localparam logic [3:0] OP_LW   = 4'h4;
  localparam logic [3:0] OP_SW   = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hA;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              jump_r;
  logic [ADDR_W-1:0] target_r;

  // Opcode of the word arriving from ROM (used while in DECODE) and of the
  // latched instruction (used in every later stage).
  logic [3:0] in_op;
  logic [3:0] ir_op;
  logic [3:0] ir_rd;
  logic       in_legal;
  logic       ir_is_mem;
  logic       ir_writes_rd;
  logic       exec_jump;

  // Only the low ADDR_W bits of the jump target address ROM words.
  logic unused_target_hi;

  assign in_op = instr[3:0];
  assign ir_op = ir[3:0];
  assign ir_rd = ir[11:8];

  assign unused_target_hi = ^branch_target[31:ADDR_W];

  // Legal opcodes besides halt; halt is detected separately so it does not
  // raise the illegal flag.
  always_comb begin
    in_legal = 1'b0;
    case (in_op)
      OP_ADDI, OP_ADD, OP_JALR, OP_JEQ, OP_LW, OP_SW: in_legal = 1'b1;
      default:                                        in_legal = 1'b0;
    endcase
  end

  // Properties of the latched instruction that steer EXEC and WB.
  always_comb begin
    ir_is_mem    = (ir_op == OP_LW) || (ir_op == OP_SW);
    ir_writes_rd = 1'b0;
    case (ir_op)
      OP_ADDI, OP_ADD, OP_JALR, OP_LW: ir_writes_rd = (ir_rd != 4'd0);
      default:                         ir_writes_rd = 1'b0;
    endcase
    exec_jump    = (ir_op == OP_JALR) || ((ir_op == OP_JEQ) && branch_taken);
  end

  // Sequencer: state, PC, instruction latch, jump decision, sticky flags and
  // the retire counter all advance together; reset overrides any stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_FETCH;
      pc          <= '0;
      ir          <= '0;
      jump_r      <= 1'b0;
      target_r    <= '0;
      halted      <= 1'b0;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          // PC is held steady so the ROM word for it arrives in DECODE.
          state <= S_DECODE;
        end
        S_DECODE: begin
          ir <= instr;
          if (in_op == OP_HALT) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else if (!in_legal) begin
            illegal <= 1'b1;
            halted  <= 1'b1;
            state   <= S_HALT;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          jump_r   <= exec_jump;
          target_r <= branch_target[ADDR_W-1:0];
          state    <= ir_is_mem ? S_MEM : S_WB;
        end
        S_MEM: begin
          if (dmem_ready) begin
            state <= S_WB;
          end
        end
        S_WB: begin
          // PC+1 wraps naturally at ADDR_W bits; the counter wraps at 2^32.
          pc          <= jump_r ? target_r : pc + ADDR_W'(1);
          instr_count <= instr_count + 32'd1;
          // A step pulse in this cycle is deliberately not looked at.
          state       <= step_mode ? S_HOLD : S_FETCH;
        end
        S_HOLD: begin
          if (step || !step_mode) begin
            state <= S_FETCH;
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

  // Strobes depend only on registered state and ir, so they cannot glitch
  // with datapath inputs and drop the cycle after any reset edge.
  always_comb begin
    gr_we    = (state == S_WB) && ir_writes_rd;
    dmem_req = (state == S_MEM);
    dmem_we  = (state == S_MEM) && (ir_op == OP_SW);
  end

  assign pc_o  = pc;
  assign stage = state;

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the mother_board CPU. It owns the program counter, fetches instructions from `rom`, steps each one through FETCH/DECODE/EXEC/MEM/WB, and issues register-file and data-memory strobes to `gr_file` and `mem_file`. It detects halt and illegal opcodes, supports single-step debug, and counts retired instructions.

## Interface

Parameters:
- `ADDR_W`, 10: PC / ROM word-address width; PC counts words.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `instr`  in  32  ROM read data; valid the cycle after `pc_o` changes (1-cycle ROM latency)
- `branch_taken`  in  1  datapath compare result for jeq; sampled in EXEC
- `branch_target`  in  32  datapath rs1 value; sampled in EXEC
- `dmem_ready`  in  1  data-memory accept/complete
- `step_mode`  in  1  1 = hold after every instruction
- `step`  in  1  single-cycle pulse; releases HOLD
- `pc_o`  out  ADDR_W  current PC / ROM address
- `ir`  out  32  latched instruction for the datapath
- `gr_we`  out  1  register write strobe
- `dmem_req`  out  1  data-memory request
- `dmem_we`  out  1  data-memory write qualifier
- `halted`  out  1  sticky halt
- `illegal`  out  1  sticky illegal-opcode flag
- `stage`  out  3  state encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HOLD=5, HALT=6
- `instr_count`  out  32  retired-instruction counter

## Operation

- Instruction fields: imm[31:20], rs2[19:16], rs1[15:12], rd[11:8], opt[7:4], opcode[3:0].
- Opcodes: 0 addi, 1 add, 2 jalr, 3 jeq, 4 lw, 5 sw, A halt. Every other opcode is illegal.
- **FETCH**: `pc_o` is stable. Next state is DECODE.
- **DECODE**: latch `instr` into `ir` at the end of the cycle.
  - halt goes to HALT.
  - An illegal opcode sets `illegal` and goes to HALT.
  - Anything else goes to EXEC.
- **EXEC**:
  - Register the jump decision: jalr always jumps; jeq jumps if `branch_taken`.
  - Register `branch_target[ADDR_W-1:0]`; upper bits are ignored.
  - lw and sw go to MEM; everything else goes to WB.
- **MEM**:
  - `dmem_req`=1 throughout; `dmem_we`=1 for sw only.
  - Stay in MEM until `dmem_ready`=1 is sampled, then go to WB.
- **WB**:
  - `gr_we`=1 for addi, add, jalr and lw, only when rd≠0. It is 0 for jeq and sw.
  - PC ← jump ? target : PC+1. PC+1 wraps modulo 2^ADDR_W.
  - `instr_count` increments. It wraps at 2^32.
  - Next state is HOLD if `step_mode`, else FETCH.
- **HOLD**: go to FETCH on `step`=1 or `step_mode`=0. A `step` pulse outside HOLD is ignored.
- **HALT**: terminal state; `halted`=1. Only `reset` leaves it.
- halt and illegal instructions are not counted in `instr_count`.
- `gr_we`, `dmem_req` and `dmem_we` are decoded from the state register and `ir` only (Moore outputs, glitch-free relative to the inputs).

## Timing

- Reset values: state FETCH, `pc_o`=0, `ir`=0, `gr_we`=0, `dmem_req`=0, `dmem_we`=0, `halted`=0, `illegal`=0, `instr_count`=0.
- Reset takes priority over every transition, including mid-MEM. `dmem_req` is 0 in the cycle after the reset edge; an outstanding memory request is abandoned.
- First cycle after reset deasserts: FETCH with `pc_o`=0.
- Latency:
  - addi, add, jalr, jeq: 4 cycles (F, D, E, W).
  - lw, sw: 4 + N cycles, where N ≥ 1 is the number of MEM cycles up to and including the first `dmem_ready`=1.
  - halt: 2 cycles to HALT.
- `gr_we` is a 1-cycle pulse in WB. The new PC is visible on `pc_o` in the following FETCH.
- `dmem_ready` is ignored outside MEM.
- `step` arriving in the same cycle as WB is ignored; the block still enters HOLD.

## Test plan

- addi 0x00100100, then halt 0x0000000A, reset released at cycle 0:
  - cycles 1..4 show `stage` 0, 1, 2, 4; `gr_we`=1 only in cycle 4.
  - `pc_o`=1 in cycle 5; `halted`=1 from cycle 7.
  - `instr_count`=1; `illegal`=0.
- sw 0x00032005 with `dmem_ready` held low for 2 MEM cycles, high on the 3rd:
  - `dmem_req`=`dmem_we`=1 for exactly 3 cycles; `gr_we` never 1.
  - next FETCH has `pc_o`=1.
- jalr 0x00003402 at pc 2 with `branch_target`=7: `gr_we` pulses; next FETCH has `pc_o`=7.
- jeq 0x00023003 at pc 2, `branch_target`=7:
  - `branch_taken`=0 gives next `pc_o`=3.
  - `branch_taken`=1 gives `pc_o`=7.
  - `gr_we`=0 in both cases.
- Opcode 0xF at pc 0: `illegal`=1 and `halted`=1 from cycle 3; `instr_count`=0; `pc_o` stays 0.
- Two-instruction program with `step_mode`=1:
  - after the first WB, `stage` stays at 5 for 10 cycles.
  - a `step` pulse gives FETCH with `pc_o`=1 on the next cycle.
- Reset asserted during the 2nd MEM cycle of a lw: next cycle shows `stage`=0, `pc_o`=0, `dmem_req`=0, `instr_count`=0.
